mouse_receiver: RTL and testbench
=================================

MOUSE_RECEIVER -- requirements
Module: mouse_receiver

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 50000, CLK cycles allowed between consecutive mouse-clock falling edges inside a frame before the frame is abandoned.
REQ-002 SHALL have port CLK  input  1  system clock (100 MHz); all state changes on its rising edge.
REQ-003 SHALL have port RESET  input  1  asynchronous, active-low reset: asserted when low, applied immediately regardless of CLK.
REQ-004 SHALL have port CLK_MOUSE_IN  input  1  PS/2 clock sampled from the bidirectional CLK_MOUSE line.
REQ-005 SHALL have port DATA_MOUSE_IN  input  1  PS/2 data sampled from the bidirectional DATA_MOUSE line.
REQ-006 SHALL have port READ_ENABLE  input  1  receiver enable; low while the upstream transmitter owns the bus.
REQ-007 SHALL have port BYTE_READY  output  1  one-cycle strobe marking a completed frame.
REQ-008 SHALL have port BYTE_READ  output  8  received data byte, LSB first on the wire.
REQ-009 SHALL have port BYTE_ERROR_CODE  output  2  bit0 parity error, bit1 stop-bit error, both for the frame flagged by BYTE_READY.

Function
REQ-010 SHALL pass CLK_MOUSE_IN and DATA_MOUSE_IN each through a 2-flop synchronizer before any use.
REQ-011 SHALL detect a mouse-clock falling edge as synchronized clock high on the previous cycle and low on the current cycle; all bit sampling SHALL use synchronized data on that cycle.
REQ-012 SHALL implement states IDLE, DATA, PARITY, STOP, DONE.
REQ-013 IDLE: on a falling edge with data 0 (start bit) go to DATA with bit count 0; a falling edge with data 1 SHALL be ignored.
REQ-014 DATA: each falling edge shifts data into bit position count (LSB first); after the 8th bit go to PARITY.
REQ-015 PARITY: on a falling edge latch the parity bit and go to STOP; odd parity required (XOR of 8 data bits and parity bit = 1).
REQ-016 STOP: on a falling edge latch the stop bit (required 1) and go to DONE.
REQ-017 DONE: for exactly one CLK cycle drive BYTE_READY=1, update BYTE_READ and BYTE_ERROR_CODE, then return to IDLE unconditionally.
REQ-018 BYTE_READY SHALL occur no later than 4 CLK cycles after the stop-bit falling edge at CLK_MOUSE_IN.
REQ-019 BYTE_READ and BYTE_ERROR_CODE SHALL hold their values between strobes.
REQ-020 Errors SHALL NOT suppress BYTE_READY; the byte is delivered with its error code set.
REQ-021 Timeout counter SHALL clear on every detected falling edge and in IDLE, increment in DATA/PARITY/STOP, and on reaching TIMEOUT_CYCLES force IDLE without BYTE_READY and discard partial data.
REQ-022 READ_ENABLE low SHALL force IDLE on the next cycle, ignore all edges, and abort any partial frame without BYTE_READY.
REQ-023 READ_ENABLE rising SHALL NOT treat a line already low as a start bit; only a subsequent falling edge counts.
REQ-024 Timeout and READ_ENABLE low on the same cycle SHALL both yield IDLE with no strobe.

Reset
REQ-025 On RESET low: state IDLE, counters 0, BYTE_READY 0, BYTE_READ 0x00, BYTE_ERROR_CODE 2'b00, synchronizer flops 1 (idle-high bus).
REQ-026 Reset asserted mid-frame SHALL discard the frame; no BYTE_READY after release until a new complete frame arrives.

Configuration
REQ-027 Macro MOUSE_RX_PARITY_CHECK_EN defined: BYTE_ERROR_CODE[0] reports parity check per REQ-015.
REQ-028 Macro MOUSE_RX_PARITY_CHECK_EN undefined: parity bit still consumed as a frame slot, BYTE_ERROR_CODE[0] tied 0; all other behaviour unchanged.

Verification
REQ-029 Frame 0xFA, parity 1, stop 1, bit period 40 CLK, READ_ENABLE=1 -> one BYTE_READY pulse, BYTE_READ=0xFA, BYTE_ERROR_CODE=00.
REQ-030 Frame 0xFA, parity 0, stop 1 -> BYTE_READ=0xFA, BYTE_ERROR_CODE=01 with macro defined, 00 without.
REQ-031 Frame 0x08, parity 0, stop 0 -> BYTE_READ=0x08, BYTE_ERROR_CODE=10.
REQ-032 TIMEOUT_CYCLES=200: start bit + 3 data bits, clock held high 300 CLK, then full frame 0x08 parity 0 stop 1 -> exactly one BYTE_READY, BYTE_READ=0x08, code 00.
REQ-033 READ_ENABLE dropped after 4th data bit, raised, then full frame 0x00 parity 1 -> single BYTE_READY, BYTE_READ=0x00, code 00.
REQ-034 RESET low for 20 ns mid-frame (after 5 data bits), remainder sent -> no BYTE_READY, outputs 0; next frame 0xAA parity 1 -> BYTE_READ=0xAA, code 00.

Source files
------------

// File: rtl/mouse_receiver.sv
// PS/2 mouse receive path: start, 8 data bits (LSB first), parity, stop.
// Define MOUSE_RX_PARITY_CHECK_EN to report odd-parity errors in bit 0 of BYTE_ERROR_CODE.
module mouse_receiver #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CLK_MOUSE_IN,
  input  logic       DATA_MOUSE_IN,
  input  logic       READ_ENABLE,
  output logic       BYTE_READY,
  output logic [7:0] BYTE_READ,
  output logic [1:0] BYTE_ERROR_CODE
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_DONE
  } state_e;

  logic          clk_s1_q;
  logic          clk_s2_q;
  logic          clk_prev_q;
  logic          dat_s1_q;
  logic          dat_s2_q;
  logic          fall;

  state_e        state_q;
  logic [2:0]    cnt_q;
  logic [TW-1:0] timer_q;
  logic [7:0]    shift_q;
  logic          byte_ready_q;
  logic [7:0]    byte_read_q;
  logic [1:0]    err_q;
  logic          perr;

`ifdef MOUSE_RX_PARITY_CHECK_EN
  logic          par_q;
  // Odd parity: data bits plus parity bit must XOR to 1.
  assign perr = ~(^{shift_q, par_q});
`else
  assign perr = 1'b0;
`endif

  // Two-flop synchronizers plus previous-clock flop; idle bus is high.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
    end else begin
      clk_s1_q   <= CLK_MOUSE_IN;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      dat_s1_q   <= DATA_MOUSE_IN;
      dat_s2_q   <= dat_s1_q;
    end
  end

  assign fall = clk_prev_q & ~clk_s2_q;

  // Frame FSM with timeout and enable abort; outputs registered here.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q      <= S_IDLE;
      cnt_q        <= 3'd0;
      timer_q      <= '0;
      shift_q      <= 8'h00;
      byte_ready_q <= 1'b0;
      byte_read_q  <= 8'h00;
      err_q        <= 2'b00;
`ifdef MOUSE_RX_PARITY_CHECK_EN
      par_q        <= 1'b0;
`endif
    end else begin
      byte_ready_q <= 1'b0;
      if (!READ_ENABLE) begin
        state_q <= S_IDLE;
        cnt_q   <= 3'd0;
        timer_q <= '0;
        shift_q <= 8'h00;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            timer_q <= '0;
            if (fall && !dat_s2_q) begin
              state_q <= S_DATA;
              cnt_q   <= 3'd0;
              shift_q <= 8'h00;
            end
          end
          S_DATA: begin
            if (fall) begin
              timer_q         <= '0;
              shift_q[cnt_q]  <= dat_s2_q;
              cnt_q           <= cnt_q + 3'd1;
              if (cnt_q == 3'd7) begin
                state_q <= S_PARITY;
              end
            end else if (timer_q == TLAST) begin
              state_q <= S_IDLE;
              timer_q <= '0;
              cnt_q   <= 3'd0;
              shift_q <= 8'h00;
            end else begin
              timer_q <= timer_q + 1'b1;
            end
          end
          S_PARITY: begin
            if (fall) begin
              timer_q <= '0;
`ifdef MOUSE_RX_PARITY_CHECK_EN
              par_q   <= dat_s2_q;
`endif
              state_q <= S_STOP;
            end else if (timer_q == TLAST) begin
              state_q <= S_IDLE;
              timer_q <= '0;
              cnt_q   <= 3'd0;
              shift_q <= 8'h00;
            end else begin
              timer_q <= timer_q + 1'b1;
            end
          end
          S_STOP: begin
            if (fall) begin
              timer_q      <= '0;
              byte_read_q  <= shift_q;
              err_q        <= {~dat_s2_q, perr};
              byte_ready_q <= 1'b1;
              state_q      <= S_DONE;
            end else if (timer_q == TLAST) begin
              state_q <= S_IDLE;
              timer_q <= '0;
              cnt_q   <= 3'd0;
              shift_q <= 8'h00;
            end else begin
              timer_q <= timer_q + 1'b1;
            end
          end
          S_DONE: begin
            state_q <= S_IDLE;
            timer_q <= '0;
            cnt_q   <= 3'd0;
          end
          default: begin
            state_q <= S_IDLE;
            timer_q <= '0;
            cnt_q   <= 3'd0;
          end
        endcase
      end
    end
  end

  assign BYTE_READY      = byte_ready_q;
  assign BYTE_READ       = byte_read_q;
  assign BYTE_ERROR_CODE = err_q;

endmodule

// File: tb/tb_mouse_receiver.sv
// Scoreboard bench for mouse_receiver: directed PS/2 frames,
// timeout, enable abort and mid-frame reset.
module tb_mouse_receiver;

  logic       clk;
  logic       rst_n;
  logic       mclk;
  logic       mdat;
  logic       ren;
  logic       rdy;
  logic [7:0] rbyte;
  logic [1:0] rcode;

  int checks = 0;
  int failures = 0;

  logic [9:0] exp_q [$];
  logic       prev_rdy = 1'b0;

`ifdef MOUSE_RX_PARITY_CHECK_EN
  localparam logic [1:0] PAR_ERR = 2'b01;
`else
  localparam logic [1:0] PAR_ERR = 2'b00;
`endif

  mouse_receiver #(.TIMEOUT_CYCLES(200)) dut (
    .CLK(clk),
    .RESET(rst_n),
    .CLK_MOUSE_IN(mclk),
    .DATA_MOUSE_IN(mdat),
    .READ_ENABLE(ren),
    .BYTE_READY(rdy),
    .BYTE_READ(rbyte),
    .BYTE_ERROR_CODE(rcode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor: pop expected byte/code on every strobe.
  always @(negedge clk) begin
    logic [9:0] e;
    if (rdy) begin
      checks++;
      if (prev_rdy) begin
        failures++;
        $display("FAIL strobe_width: BYTE_READY high 2 cycles, required 1");
      end
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_strobe: byte=%02h code=%02b, none expected",
                 rbyte, rcode);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (rbyte !== e[9:2]) begin
          failures++;
          $display("FAIL byte: got %02h required %02h", rbyte, e[9:2]);
        end
        checks++;
        if (rcode !== e[1:0]) begin
          failures++;
          $display("FAIL code: got %02b required %02b (byte %02h)",
                   rcode, e[1:0], e[9:2]);
        end
      end
    end
    prev_rdy = rdy;
  end

  function automatic logic [10:0] frame(input logic [7:0] d,
                                        input logic p,
                                        input logic s);
    return {s, p, d, 1'b0};
  endfunction

  task automatic check(input string name, input logic [7:0] got,
                       input logic [7:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s: got %02h required %02h", name, got, req);
    end
  endtask

  // One PS/2 bit: data set while clock high, then 20-cycle low phase.
  task automatic mouse_bit(input logic b, input bit last, input bit exp_rdy);
    int lat;
    mdat = b;
    repeat (20) @(negedge clk);
    mclk = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (last && lat < 0 && rdy) lat = i;
    end
    mclk = 1'b1;
    if (last && exp_rdy) begin
      checks++;
      if (lat < 1 || lat > 4) begin
        failures++;
        $display("FAIL latency: got %0d cycles required 1..4", lat);
      end
    end
  endtask

  task automatic send_bits(input logic [10:0] f, input int lo,
                           input int hi, input bit exp_rdy);
    for (int i = lo; i <= hi; i++) mouse_bit(f[i], i == 10, exp_rdy);
    mdat = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p,
                            input logic s, input logic [1:0] code);
    exp_q.push_back({d, code});
    send_bits(frame(d, p, s), 0, 10, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0;
    mclk  = 1'b1;
    mdat  = 1'b1;
    ren   = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_ready", {7'd0, rdy}, 8'h00);
    check("reset_byte", rbyte, 8'h00);
    check("reset_code", {6'd0, rcode}, 8'h00);

    send_frame(8'hFA, 1'b1, 1'b1, 2'b00);
    send_frame(8'hFA, 1'b0, 1'b1, PAR_ERR);
    send_frame(8'h08, 1'b0, 1'b0, 2'b10);

    repeat (50) @(negedge clk);
    check("hold_byte", rbyte, 8'h08);
    check("hold_code", {6'd0, rcode}, 8'h02);

    // Reset after 5 data bits, then the rest of the frame.
    send_bits(frame(8'hAA, 1'b1, 1'b1), 0, 5, 1'b0);
    #3;
    rst_n = 1'b0;
    #20;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_byte", rbyte, 8'h00);
    check("midrst_code", {6'd0, rcode}, 8'h00);
    send_bits(frame(8'hAA, 1'b1, 1'b1), 6, 10, 1'b0);
    repeat (300) @(negedge clk);
    check("midrst_ready", {7'd0, rdy}, 8'h00);
    send_frame(8'hAA, 1'b1, 1'b1, 2'b00);

    // Timeout: start + 3 data bits, clock idle 300 cycles.
    send_bits(frame(8'h55, 1'b1, 1'b1), 0, 3, 1'b0);
    repeat (280) @(negedge clk);
    send_frame(8'h08, 1'b0, 1'b1, 2'b00);

    // Enable drop after 4 data bits; re-enable with line already low.
    send_bits(frame(8'hFF, 1'b1, 1'b1), 0, 4, 1'b0);
    ren = 1'b0;
    repeat (5) @(negedge clk);
    mdat = 1'b0;
    mclk = 1'b0;
    repeat (10) @(negedge clk);
    ren = 1'b1;
    repeat (10) @(negedge clk);
    mclk = 1'b1;
    mdat = 1'b1;
    repeat (20) @(negedge clk);
    send_frame(8'h00, 1'b1, 1'b1, 2'b00);

    repeat (100) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_strobes: got %0d pending required 0",
               exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
